// File: rtl/hsk_uart_pkg.sv
// Shared constants and increment calculation for the housekeeping UART baud-rate generator.
// The calculation function is shared with the software-header generator.
package hsk_uart_pkg;

    localparam int HSK_BRG_ACC_WIDTH   = 9;
    localparam int HSK_BRG_DEFAULT_INC = 41;

    // Rounded increment: baud * oversample * 2^acc_width / f_clk.
    function automatic int unsigned hsk_brg_calc_inc(
        input longint unsigned f_clk_hz,
        input longint unsigned baud,
        input int unsigned     oversample,
        input int unsigned     acc_width
    );
        longint unsigned num;
        num = baud * longint'(oversample) * (64'd1 << acc_width);
        return 32'((num + (f_clk_hz / 2)) / f_clk_hz);
    endfunction

endpackage

// File: rtl/hsk_brg_accum.sv
// Fractional phase accumulator: the top bit holds the registered carry of the last addition.
// The carry is cleared on every addition, so it is high for at most one enabled cycle per wrap.
module hsk_brg_accum
    import hsk_uart_pkg::*;
#(
    parameter int ACC_WIDTH = HSK_BRG_ACC_WIDTH,
    parameter int INC_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic                 clr,
    input  logic [INC_WIDTH-1:0] inc,
    output logic                 carry
);

    localparam int SUM_W = ACC_WIDTH + 1;

    logic [ACC_WIDTH:0] acc_q;
    logic [ACC_WIDTH:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = {1'b0, acc_q[ACC_WIDTH-1:0]} + SUM_W'(inc);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign carry = acc_q[ACC_WIDTH];

endmodule

// File: rtl/hsk_uart_frac_brg.sv
// Fractional-N baud-rate generator: oversample tick, bit tick and phase index, with an
// increment register that only changes at a bit boundary, while held, or on restart.
module hsk_uart_frac_brg
    import hsk_uart_pkg::*;
#(
    parameter int ACC_WIDTH   = HSK_BRG_ACC_WIDTH,
    parameter int INC_WIDTH   = 9,
    parameter int DEFAULT_INC = HSK_BRG_DEFAULT_INC,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          enable,
    input  logic                          restart,
    input  logic                          inc_wr,
    input  logic [INC_WIDTH-1:0]          inc_in,
    output logic [INC_WIDTH-1:0]          inc_active,
    output logic                          inc_pending,
    output logic                          en_os_baud,
    output logic                          en_baud,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

    localparam int              OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic [INC_WIDTH-1:0] inc_active_q, inc_active_d;
    logic [INC_WIDTH-1:0] inc_pend_q, inc_pend_d;
    logic                 pending_q, pending_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic                 carry;
    logic                 os_tick;
    logic                 bit_tick;
    logic                 apply;

    hsk_brg_accum #(
        .ACC_WIDTH (ACC_WIDTH),
        .INC_WIDTH (INC_WIDTH)
    ) u_accum (
        .clk    (clk),
        .resetn (resetn),
        .en     (enable),
        .clr    (restart),
        .inc    (inc_active_q),
        .carry  (carry)
    );

    always_comb begin
        // Ticks are masked while held or restarting so downstream cores never see a stale carry.
        os_tick  = carry & enable & ~restart;
        bit_tick = os_tick & (os_cnt_q == OS_LAST);
        apply    = bit_tick | ~enable | restart;

        os_cnt_d = os_cnt_q;
        if (restart) begin
            os_cnt_d = '0;
        end else if (os_tick) begin
            os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
        end

        inc_active_d = inc_active_q;
        inc_pend_d   = inc_pend_q;
        pending_d    = pending_q;
        // A write landing on an apply cycle bypasses the pending register.
        if (apply) begin
            pending_d = 1'b0;
            if (inc_wr) begin
                inc_active_d = inc_in;
            end else if (pending_q) begin
                inc_active_d = inc_pend_q;
            end
        end else if (inc_wr) begin
            inc_pend_d = inc_in;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inc_active_q <= INC_WIDTH'(DEFAULT_INC);
            inc_pend_q   <= '0;
            pending_q    <= 1'b0;
            os_cnt_q     <= '0;
        end else begin
            inc_active_q <= inc_active_d;
            inc_pend_q   <= inc_pend_d;
            pending_q    <= pending_d;
            os_cnt_q     <= os_cnt_d;
        end
    end

    assign inc_active  = inc_active_q;
    assign inc_pending = pending_q;
    assign en_os_baud  = os_tick;
    assign en_baud     = bit_tick;
    assign os_phase    = os_cnt_q;

endmodule

// File: tb/tb_hsk_uart_frac_brg.sv
// Self-checking bench for hsk_uart_frac_brg: directed scenarios plus randomized traffic,
// compared every cycle against an arithmetic phase/tick model.
module tb_hsk_uart_frac_brg;

    localparam int AW  = 9;
    localparam int IW  = 9;
    localparam int OS  = 16;
    localparam int DEF = 41;
    localparam int MOD = 1 << AW;

    logic          clk     = 1'b0;
    logic          resetn  = 1'b0;
    logic          enable  = 1'b0;
    logic          restart = 1'b0;
    logic          inc_wr  = 1'b0;
    logic [IW-1:0] inc_in  = '0;
    logic [IW-1:0] inc_active;
    logic          inc_pending;
    logic          en_os_baud;
    logic          en_baud;
    logic [3:0]    os_phase;

    hsk_uart_frac_brg #(
        .ACC_WIDTH   (AW),
        .INC_WIDTH   (IW),
        .DEFAULT_INC (DEF),
        .OVERSAMPLE  (OS)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .restart     (restart),
        .inc_wr      (inc_wr),
        .inc_in      (inc_in),
        .inc_active  (inc_active),
        .inc_pending (inc_pending),
        .en_os_baud  (en_os_baud),
        .en_baud     (en_baud),
        .os_phase    (os_phase)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, got, lo, hi, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase is a plain integer modulo 2^AW; a wrap during an enabled cycle becomes the tick seen next cycle.
    int m_phase, m_carry, m_os, m_inc, m_pend, m_pend_val, m_inc_used;
    bit m_tick, m_btick, m_apply;
    bit win = 1'b0;
    int ecnt = 0;

    function automatic bit m_os_tick();
        return (m_carry != 0) && enable && !restart;
    endfunction

    function automatic bit m_bit_tick();
        return m_os_tick() && (m_os == OS - 1);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_phase    = 0;
            m_carry    = 0;
            m_os       = 0;
            m_inc      = DEF;
            m_pend     = 0;
            m_pend_val = 0;
        end else begin
            m_tick     = m_os_tick();
            m_btick    = m_bit_tick();
            m_apply    = m_btick || !enable || restart;
            m_inc_used = m_inc;
            if (m_apply) begin
                if (inc_wr) m_inc = int'(inc_in);
                else if (m_pend != 0) m_inc = m_pend_val;
                m_pend = 0;
            end else if (inc_wr) begin
                m_pend_val = int'(inc_in);
                m_pend     = 1;
            end
            if (restart) begin
                m_phase = 0;
                m_carry = 0;
            end else if (enable) begin
                m_phase = m_phase + m_inc_used;
                m_carry = (m_phase >= MOD) ? 1 : 0;
                m_phase = m_phase % MOD;
            end
            if (restart) m_os = 0;
            else if (m_tick) m_os = (m_os + 1) % OS;
            if (win && enable) ecnt++;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_on    = 1'b0;
    int os_cnt_w  = 0;
    int baud_cnt_w = 0;
    int first_os  = -1;
    int bad_phase = 0;

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("en_os_baud",  int'(en_os_baud),  int'(m_os_tick()));
            chk("en_baud",     int'(en_baud),     int'(m_bit_tick()));
            chk("os_phase",    int'(os_phase),    m_os);
            chk("inc_active",  int'(inc_active),  m_inc);
            chk("inc_pending", int'(inc_pending), m_pend);
            if (win) begin
                if (en_os_baud) begin
                    os_cnt_w++;
                    if (first_os < 0) first_os = ecnt;
                end
                if (en_baud) begin
                    baud_cnt_w++;
                    if (os_phase != 4'd15) bad_phase++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int ph, input string nm);
        int n = 0;
        while (int'(os_phase) != ph && n < 1000) begin
            step();
            n++;
        end
        chk({nm, "_timeout"}, int'(n < 1000), 1);
    endtask

    task automatic wait_baud(input string nm);
        int n = 0;
        while (!en_baud && n < 1000) begin
            step();
            n++;
        end
        chk({nm, "_timeout"}, int'(n < 1000), 1);
    endtask

    // ---------------- stimulus ----------------
    int n;
    int gap_ticks;
    int zero_ticks;

    initial begin
        cmp_on = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_inc_active",  int'(inc_active),  41);
        chk("rst_inc_pending", int'(inc_pending), 0);
        chk("rst_os_phase",    int'(os_phase),    0);
        chk("rst_en_os_baud",  int'(en_os_baud),  0);
        chk("rst_en_baud",     int'(en_baud),     0);
        @(negedge clk);
        resetn = 1'b1;

        // Default rate over 8192 enabled edges.
        step();
        enable = 1'b1;
        win    = 1'b1;
        ecnt   = 0;
        repeat (8192) @(posedge clk);
        @(negedge clk);
        #1;
        win = 1'b0;
        chk("default_os_ticks",   os_cnt_w,   656);
        chk("default_bit_ticks",  baud_cnt_w, 41);
        chk("default_first_tick", first_os,   13);
        chk("default_bad_phase",  bad_phase,  0);

        // Live increment update mid-bit.
        wait_phase(7, "wait_ph7");
        inc_wr = 1'b1;
        inc_in = 9'd82;
        step();
        inc_wr = 1'b0;
        chk("upd_pending_set", int'(inc_pending), 1);
        chk("upd_active_old",  int'(inc_active),  41);
        wait_baud("wait_apply");
        chk("upd_pending_at_apply", int'(inc_pending), 1);
        step();
        chk("upd_active_new",  int'(inc_active),  82);
        chk("upd_pending_clr", int'(inc_pending), 0);
        n = 0;
        while (!en_baud && n < 400) begin
            step();
            n++;
        end
        chk_range("upd_bit_period", n + 1, 99, 102);

        // Restart at os_phase 9, with a same-cycle write of 41 applied directly.
        wait_phase(9, "wait_ph9");
        restart = 1'b1;
        inc_wr  = 1'b1;
        inc_in  = 9'd41;
        @(negedge clk);
        chk("restart_cycle_os",   int'(en_os_baud), 0);
        chk("restart_cycle_baud", int'(en_baud),    0);
        @(posedge clk);
        #1;
        restart = 1'b0;
        inc_wr  = 1'b0;
        chk("restart_os_phase", int'(os_phase),    0);
        chk("restart_inc",      int'(inc_active),  41);
        chk("restart_pending",  int'(inc_pending), 0);
        n = 0;
        while (!en_os_baud && n < 100) begin
            step();
            n++;
        end
        chk("restart_first_tick", n, 13);

        // Enable hold for 37 cycles with a write inside the gap.
        wait_phase(5, "wait_ph5");
        enable    = 1'b0;
        gap_ticks = 0;
        for (int i = 0; i < 37; i++) begin
            step();
            if (en_os_baud || en_baud) gap_ticks++;
            if (i == 10) begin
                inc_wr = 1'b1;
                inc_in = 9'd60;
            end
            if (i == 11) begin
                inc_wr = 1'b0;
                chk("hold_write_active",  int'(inc_active),  60);
                chk("hold_write_pending", int'(inc_pending), 0);
            end
        end
        chk("hold_no_ticks", gap_ticks, 0);
        chk("hold_os_phase", int'(os_phase), 5);
        enable = 1'b1;

        // Zero increment applied at a bit boundary freezes the generator.
        wait_phase(3, "wait_ph3");
        inc_wr = 1'b1;
        inc_in = 9'd0;
        step();
        inc_wr = 1'b0;
        chk("zero_pending", int'(inc_pending), 1);
        wait_baud("wait_zero_apply");
        step();
        chk("zero_active", int'(inc_active), 0);
        zero_ticks = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (en_os_baud || en_baud) zero_ticks++;
        end
        chk("zero_no_ticks", zero_ticks, 0);

        // Async reset in the middle of tick generation.
        enable = 1'b0;
        inc_wr = 1'b1;
        inc_in = 9'd200;
        step();
        inc_wr = 1'b0;
        enable = 1'b1;
        chk("fast_active", int'(inc_active), 200);
        repeat (5) step();
        inc_wr = 1'b1;
        inc_in = 9'd99;
        step();
        inc_wr = 1'b0;
        n = 0;
        while (!en_os_baud && n < 20) begin
            step();
            n++;
        end
        chk("areset_tick_seen", int'(en_os_baud), 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_os",         int'(en_os_baud),  0);
        chk("areset_baud",       int'(en_baud),     0);
        chk("areset_os_phase",   int'(os_phase),    0);
        chk("areset_pending",    int'(inc_pending), 0);
        chk("areset_inc_active", int'(inc_active),  41);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Randomized traffic checked by the per-cycle compare.
        for (int i = 0; i < 3000; i++) begin
            step();
            enable  = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 39) == 0);
            inc_wr  = ($urandom_range(0, 24) == 0);
            inc_in  = ($urandom_range(0, 15) == 0) ? '0 : IW'($urandom_range(1, 511));
        end
        step();
        enable  = 1'b1;
        restart = 1'b0;
        inc_wr  = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
